// File: rtl/apb_intercon_rr.sv
// rtl/apb_intercon_rr.sv - multi-master to multi-slave APB interconnect, round-robin arbitrated
//
// Purpose: arbitrates MASTER_PORTS APB masters onto one shared APB slave bus,
// decodes the slave index from PADDR, returns per-slave read data/ready to the
// granted master, and completes unmapped or stuck accesses with PSLVERR.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   S_PADDR    master addresses, slice i = master i
//   S_PWRITE   master write flags
//   S_PSELx    master transfer requests
//   S_PENABLE  master enables (not used for arbitration)
//   S_PWDATA   master write data, slice i = master i
//   S_PRDATA   read data returned to every master slice on completion
//   S_PREADY   one-hot completion pulse to the granted master
//   S_PSLVERR  error flag accompanying the completion pulse
//   M_PADDR    shared slave address (captured at grant)
//   M_PWRITE   shared write flag (captured at grant)
//   M_PSELx    one-hot slave select
//   M_PENABLE  shared enable, high in ACCESS
//   M_PWDATA   shared write data (captured at grant)
//   M_PRDATA   per-slave read data, slice s = slave s
//   M_PREADY   per-slave ready
//   grant      index of the current / most recently granted master
//   busy       high while in SETUP or ACCESS

module apb_intercon_rr #(
   parameter int MASTER_PORTS = 4,
   parameter int SLAVE_PORTS  = 8,
   parameter int BUS_WIDTH    = 16,
   parameter int SEL_LSB      = 8,
   parameter int TIMEOUT      = 255
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [MASTER_PORTS*BUS_WIDTH-1:0]     S_PADDR,
   input  logic [MASTER_PORTS-1:0]               S_PWRITE,
   input  logic [MASTER_PORTS-1:0]               S_PSELx,
   input  logic [MASTER_PORTS-1:0]               S_PENABLE,
   input  logic [MASTER_PORTS*BUS_WIDTH-1:0]     S_PWDATA,
   output logic [MASTER_PORTS*BUS_WIDTH-1:0]     S_PRDATA,
   output logic [MASTER_PORTS-1:0]               S_PREADY,
   output logic [MASTER_PORTS-1:0]               S_PSLVERR,
   output logic [BUS_WIDTH-1:0]                  M_PADDR,
   output logic                                  M_PWRITE,
   output logic [SLAVE_PORTS-1:0]                M_PSELx,
   output logic                                  M_PENABLE,
   output logic [BUS_WIDTH-1:0]                  M_PWDATA,
   input  logic [SLAVE_PORTS*BUS_WIDTH-1:0]      M_PRDATA,
   input  logic [SLAVE_PORTS-1:0]                M_PREADY,
   output logic [(MASTER_PORTS > 1 ? $clog2(MASTER_PORTS) : 1)-1:0] grant,
   output logic                                  busy
);

   localparam int GW   = (MASTER_PORTS > 1) ? $clog2(MASTER_PORTS) : 1;
   localparam int SELW = (SLAVE_PORTS > 1) ? $clog2(SLAVE_PORTS) : 1;
   localparam int CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [GW-1:0]   LAST_MASTER = GW'(MASTER_PORTS - 1);
   localparam logic [SELW:0]   SLV_LIMIT   = (SELW + 1)'(SLAVE_PORTS);
   localparam logic [CW-1:0]   CNT_LAST    = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
   localparam logic [CW-1:0]   CNT_MAX     = '1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [GW-1:0]     ptr;
   logic [SELW-1:0]   idx;
   logic              mapped;
   logic [CW-1:0]     cnt;

   // arbitration and decode of the winning request
   logic                 req_any;
   logic [GW-1:0]        pick;
   logic [BUS_WIDTH-1:0] pick_addr;
   logic [BUS_WIDTH-1:0] pick_wdata;
   logic                 pick_write;
   logic [SELW-1:0]      pick_idx;
   logic                 pick_mapped;

   // completion terms for the slave currently addressed
   logic                 sel_ready;
   logic [BUS_WIDTH-1:0] sel_rdata;
   logic                 done_ok;
   logic                 done_unmapped;
   logic                 done_timeout;
   logic                 done;
   logic                 done_err;

   // First requester found searching upward from the slot after the last
   // granted master, wrapping, so every requester is served within N-1 turns.
   always_comb begin
      int c;
      req_any = 1'b0;
      pick    = ptr;
      c       = 0;
      for (int k = 1; k <= MASTER_PORTS; k++) begin
         c = (int'(ptr) + k) % MASTER_PORTS;
         if (!req_any && S_PSELx[c]) begin
            req_any = 1'b1;
            pick    = GW'(c);
         end
      end
   end

   always_comb begin
      pick_addr   = S_PADDR[int'(pick)*BUS_WIDTH +: BUS_WIDTH];
      pick_wdata  = S_PWDATA[int'(pick)*BUS_WIDTH +: BUS_WIDTH];
      pick_write  = S_PWRITE[pick];
      pick_idx    = pick_addr[SEL_LSB +: SELW];
      pick_mapped = ({1'b0, pick_idx} < SLV_LIMIT);
   end

   // Slave mux written as a compare loop so an unmapped index never forms an
   // out-of-range select.
   always_comb begin
      sel_ready = 1'b0;
      sel_rdata = '0;
      for (int s = 0; s < SLAVE_PORTS; s++) begin
         if (idx == SELW'(s)) begin
            sel_ready = M_PREADY[s];
            sel_rdata = M_PRDATA[s*BUS_WIDTH +: BUS_WIDTH];
         end
      end
   end

   always_comb begin
      done_ok       = (state == ST_ACCESS) && mapped && sel_ready;
      done_unmapped = (state == ST_ACCESS) && !mapped;
      done_timeout  = (TIMEOUT != 0) && (state == ST_ACCESS) && mapped &&
                      !sel_ready && (cnt == CNT_LAST);
      done          = done_ok || done_unmapped || done_timeout;
      done_err      = done_unmapped || done_timeout;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (req_any) state_nxt = ST_SETUP;
         ST_SETUP:  state_nxt = ST_ACCESS;
         ST_ACCESS: if (done) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != ST_IDLE);
      M_PENABLE = (state == ST_ACCESS);
      M_PSELx   = '0;
      for (int s = 0; s < SLAVE_PORTS; s++) begin
         M_PSELx[s] = busy && mapped && (idx == SELW'(s));
      end
      S_PREADY  = '0;
      S_PSLVERR = '0;
      S_PRDATA  = '0;
      for (int m = 0; m < MASTER_PORTS; m++) begin
         S_PREADY[m]  = done && (grant == GW'(m));
         S_PSLVERR[m] = done_err && (grant == GW'(m));
         S_PRDATA[m*BUS_WIDTH +: BUS_WIDTH] = done_ok ? sel_rdata : '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr      <= LAST_MASTER;
         grant    <= LAST_MASTER;
         M_PADDR  <= '0;
         M_PWRITE <= 1'b0;
         M_PWDATA <= '0;
         idx      <= '0;
         mapped   <= 1'b0;
         cnt      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_any) begin
                  grant    <= pick;
                  M_PADDR  <= pick_addr;
                  M_PWRITE <= pick_write;
                  M_PWDATA <= pick_wdata;
                  idx      <= pick_idx;
                  mapped   <= pick_mapped;
                  cnt      <= '0;
               end
            end
            ST_ACCESS: begin
               if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
               if (done) ptr <= grant;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_intercon_rr.sv
// tb/tb_apb_intercon_rr.sv - scoreboard bench for apb_intercon_rr

module tb_apb_intercon_rr;

   localparam int NM = 4;
   localparam int NS = 6;
   localparam int BW = 16;
   localparam int TO = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic [NM*BW-1:0]  S_PADDR;
   logic [NM-1:0]     S_PWRITE;
   logic [NM-1:0]     S_PSELx;
   logic [NM-1:0]     S_PENABLE;
   logic [NM*BW-1:0]  S_PWDATA;
   logic [NM*BW-1:0]  S_PRDATA;
   logic [NM-1:0]     S_PREADY;
   logic [NM-1:0]     S_PSLVERR;
   logic [BW-1:0]     M_PADDR;
   logic              M_PWRITE;
   logic [NS-1:0]     M_PSELx;
   logic              M_PENABLE;
   logic [BW-1:0]     M_PWDATA;
   logic [NS*BW-1:0]  M_PRDATA;
   logic [NS-1:0]     M_PREADY;
   logic [1:0]        grant;
   logic              busy;

   always #5 clk = ~clk;

   apb_intercon_rr #(
      .MASTER_PORTS(NM),
      .SLAVE_PORTS (NS),
      .BUS_WIDTH   (BW),
      .SEL_LSB     (8),
      .TIMEOUT     (TO)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .S_PADDR  (S_PADDR),
      .S_PWRITE (S_PWRITE),
      .S_PSELx  (S_PSELx),
      .S_PENABLE(S_PENABLE),
      .S_PWDATA (S_PWDATA),
      .S_PRDATA (S_PRDATA),
      .S_PREADY (S_PREADY),
      .S_PSLVERR(S_PSLVERR),
      .M_PADDR  (M_PADDR),
      .M_PWRITE (M_PWRITE),
      .M_PSELx  (M_PSELx),
      .M_PENABLE(M_PENABLE),
      .M_PWDATA (M_PWDATA),
      .M_PRDATA (M_PRDATA),
      .M_PREADY (M_PREADY),
      .grant    (grant),
      .busy     (busy)
   );

   typedef struct {
      int          m;
      logic [15:0] addr;
      logic        write;
      logic [15:0] wdata;
      logic [5:0]  psel;
      int          acc;
      logic        err;
      logic [15:0] rdata;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   // master request = outstanding issued transfers not yet completed
   int issued_n[NM] = '{default: 0};
   int served_n[NM] = '{default: 0};

   always_comb begin
      S_PSELx = '0;
      for (int m = 0; m < NM; m++) S_PSELx[m] = (issued_n[m] > served_n[m]);
   end
   assign S_PENABLE = S_PSELx;

   // slave models: slave s is ready after slv_wait[s] wait states
   int slv_wait[NS] = '{default: 0};
   int tb_acc = 0;

   always @(posedge clk) tb_acc <= M_PENABLE ? tb_acc + 1 : 0;

   always_comb begin
      M_PREADY = '0;
      M_PRDATA = '0;
      for (int s = 0; s < NS; s++) begin
         M_PREADY[s] = M_PSELx[s] && M_PENABLE && (tb_acc >= slv_wait[s]);
         M_PRDATA[s*BW +: BW] = (s == 1) ? 16'hBEEF : (16'hA000 + 16'(s));
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // monitor: pops the scoreboard on every completion pulse
   logic [NS-1:0] seen_psel = '0;
   int            acc_n     = 0;
   exp_t          me;

   always @(negedge clk) begin
      if (reset) begin
         if (busy && !M_PENABLE) begin
            seen_psel = M_PSELx;
            acc_n     = 0;
         end
         if (M_PENABLE) begin
            acc_n++;
            chk("psel_hold", 64'(M_PSELx), 64'(seen_psel));
         end
         if (S_PREADY != '0) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_completion: got pready %0h expected none", S_PREADY);
            end else begin
               me = sb.pop_front();
               chk("pready",  64'(S_PREADY),  64'(1 << me.m));
               chk("grant",   64'(grant),     64'(me.m));
               chk("pslverr", 64'(S_PSLVERR), me.err ? 64'(1 << me.m) : 64'd0);
               chk("prdata",  64'(S_PRDATA),  64'({NM{me.rdata}}));
               chk("psel",    64'(seen_psel), 64'(me.psel));
               chk("access_cycles", 64'(acc_n), 64'(me.acc));
               chk("paddr",   64'(M_PADDR),   64'(me.addr));
               chk("pwrite",  64'(M_PWRITE),  64'(me.write));
               chk("pwdata",  64'(M_PWDATA),  64'(me.wdata));
            end
            for (int m = 0; m < NM; m++) if (S_PREADY[m]) served_n[m]++;
         end
      end
   end

   task automatic issue(input int m, input logic [15:0] addr, input logic wr,
                        input logic [15:0] wd, input int n);
      S_PADDR[m*BW +: BW]  = addr;
      S_PWDATA[m*BW +: BW] = wd;
      S_PWRITE[m]          = wr;
      issued_n[m]          = issued_n[m] + n;
   endtask

   task automatic expect_tr(input int m, input logic [15:0] addr, input logic wr,
                            input logic [15:0] wd, input logic [5:0] psel, input int acc,
                            input logic err, input logic [15:0] rdata);
      exp_t e;
      e.m = m; e.addr = addr; e.write = wr; e.wdata = wd;
      e.psel = psel; e.acc = acc; e.err = err; e.rdata = rdata;
      sb.push_back(e);
   endtask

   task automatic wait_drain(input string nm, input int maxc);
      int i;
      i = 0;
      while (i < maxc && (sb.size() != 0 || busy || S_PSELx != '0)) begin
         @(negedge clk);
         i++;
      end
      checks++;
      if (sb.size() != 0 || busy || S_PSELx != '0) begin
         failures++;
         $display("FAIL %s_timeout: got %0d pending expected 0", nm, sb.size());
      end
   endtask

   initial begin
      reset    = 1'b0;
      S_PADDR  = '0;
      S_PWDATA = '0;
      S_PWRITE = '0;
      slv_wait[0] = 255;
      slv_wait[2] = 4;
      slv_wait[4] = 6;
      #12;
      chk("rst_psel",    64'(M_PSELx),   64'd0);
      chk("rst_penable", 64'(M_PENABLE), 64'd0);
      chk("rst_paddr",   64'(M_PADDR),   64'd0);
      chk("rst_pwrite",  64'(M_PWRITE),  64'd0);
      chk("rst_pwdata",  64'(M_PWDATA),  64'd0);
      chk("rst_pready",  64'(S_PREADY),  64'd0);
      chk("rst_pslverr", 64'(S_PSLVERR), 64'd0);
      chk("rst_prdata",  64'(S_PRDATA),  64'd0);
      chk("rst_busy",    64'(busy),      64'd0);
      chk("rst_grant",   64'(grant),     64'd3);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // masters 0,1,2 continuously writing slave 3: grants 0,1,2,0,1,2
      issue(0, 16'h0300, 1'b1, 16'h1111, 2);
      issue(1, 16'h0301, 1'b1, 16'h2222, 2);
      issue(2, 16'h0302, 1'b1, 16'h3333, 2);
      for (int r = 0; r < 2; r++) begin
         expect_tr(0, 16'h0300, 1'b1, 16'h1111, 6'h08, 1, 1'b0, 16'hA003);
         expect_tr(1, 16'h0301, 1'b1, 16'h2222, 6'h08, 1, 1'b0, 16'hA003);
         expect_tr(2, 16'h0302, 1'b1, 16'h3333, 6'h08, 1, 1'b0, 16'hA003);
      end
      wait_drain("rr", 100);

      // master 0 reads 0x0105 from zero-wait slave 1
      @(negedge clk);
      issue(0, 16'h0105, 1'b0, 16'h0000, 1);
      expect_tr(0, 16'h0105, 1'b0, 16'h0000, 6'h02, 1, 1'b0, 16'hBEEF);
      wait_drain("read", 40);

      // master 1 writes 0x1234 to slave 2 with 4 wait states
      @(negedge clk);
      issue(1, 16'h0200, 1'b1, 16'h1234, 1);
      expect_tr(1, 16'h0200, 1'b1, 16'h1234, 6'h04, 5, 1'b0, 16'hA002);
      wait_drain("wait", 40);

      // master 2 accesses unmapped index 7
      @(negedge clk);
      issue(2, 16'h0700, 1'b0, 16'h0000, 1);
      expect_tr(2, 16'h0700, 1'b0, 16'h0000, 6'h00, 1, 1'b1, 16'h0000);
      wait_drain("unmapped", 40);

      // master 0 to stuck slave 0: timeout on 8th ACCESS cycle
      @(negedge clk);
      issue(0, 16'h0000, 1'b0, 16'h0000, 1);
      expect_tr(0, 16'h0000, 1'b0, 16'h0000, 6'h01, 8, 1'b1, 16'h0000);
      begin
         int i;
         i = 0;
         while (i < 40 && !S_PREADY[0]) begin
            @(negedge clk);
            i++;
         end
         chk("timeout_pready", 64'(S_PREADY[0]), 64'd1);
         @(negedge clk);
         chk("timeout_psel_after", 64'(M_PSELx), 64'd0);
         chk("timeout_busy_after", 64'(busy), 64'd0);
      end
      wait_drain("timeout", 40);

      // reset asserted in ACCESS abandons master 3's transfer
      @(negedge clk);
      issue(3, 16'h0400, 1'b1, 16'h4444, 1);
      begin
         int i;
         i = 0;
         while (i < 20 && !M_PENABLE) begin
            @(negedge clk);
            i++;
         end
         chk("rst_mid_reached_access", 64'(M_PENABLE), 64'd1);
      end
      reset = 1'b0;
      #1;
      chk("rst_mid_psel",    64'(M_PSELx),   64'd0);
      chk("rst_mid_penable", 64'(M_PENABLE), 64'd0);
      chk("rst_mid_pready",  64'(S_PREADY),  64'd0);
      chk("rst_mid_busy",    64'(busy),      64'd0);
      chk("rst_mid_paddr",   64'(M_PADDR),   64'd0);
      chk("rst_mid_grant",   64'(grant),     64'd3);
      @(negedge clk);
      @(negedge clk);
      // masters 0 and 3 requesting after release: master 0 goes first
      issue(0, 16'h0500, 1'b0, 16'h0000, 1);
      expect_tr(0, 16'h0500, 1'b0, 16'h0000, 6'h20, 1, 1'b0, 16'hA005);
      expect_tr(3, 16'h0400, 1'b1, 16'h4444, 6'h10, 7, 1'b0, 16'hA004);
      reset = 1'b1;
      wait_drain("post_reset", 60);

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
